// File: rtl/mmc_blk_crc_seq.sv
// mmc_blk_crc_seq: sequences one MMC data block through an external byte-wide
// CRC16 engine. TX appends the CRC (MSB first); RX consumes and checks it.
// Optional build macro MMC_BLK_CRC_TIMEOUT_EN adds an idle-timeout abort and
// the timeout output port.
module mmc_blk_crc_seq #(
    parameter int BLK_LEN   = 512,
    parameter int TO_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    output logic        busy,
    output logic        done,
    output logic        crc_err,
    input  logic [7:0]  in_data,
    input  logic        in_vld,
    output logic        in_rdy,
    output logic [7:0]  out_data,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic        crc_rst,
    output logic [7:0]  crc_data,
    output logic        crc_dvld,
    input  logic [15:0] crc_val
`ifdef MMC_BLK_CRC_TIMEOUT_EN
    ,
    output logic        timeout
`endif
);

    localparam int CNT_W = $clog2(BLK_LEN + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLK_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_DATA, S_WAIT, S_CRC_HI, S_CRC_LO, S_CHECK
    } state_t;

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        rx_crc_q, rx_crc_d;
    logic               done_q, done_d;
    logic               crc_err_q, crc_err_d;
    logic               crc_rst_q, crc_rst_d;
    logic               crc_dvld_q, crc_dvld_d;
    logic [7:0]         crc_data_q, crc_data_d;
    logic               hs;

`ifdef MMC_BLK_CRC_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);
    logic [TO_W-1:0]    idle_q, idle_d;
    logic               to_q, to_d;
`endif

    // Next-state, datapath steering and CRC-engine control.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        rx_crc_d   = rx_crc_q;
        done_d     = 1'b0;
        crc_err_d  = crc_err_q;
        crc_rst_d  = 1'b0;
        crc_dvld_d = 1'b0;
        crc_data_d = crc_data_q;
        in_rdy     = 1'b0;
        out_vld    = 1'b0;
        out_data   = 8'h00;
        hs         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d    = mode;
                    crc_rst_d = 1'b1;   // engine held in reset for the INIT cycle
                    state_d   = S_INIT;
                end
            end
            S_INIT: begin
                cnt_d     = '0;
                crc_err_d = 1'b0;
                state_d   = S_DATA;
            end
            S_DATA: begin
                out_data = in_data;
                out_vld  = in_vld;
                in_rdy   = out_rdy;
                hs       = in_vld & out_rdy;
                if (hs) begin
                    crc_data_d = in_data;
                    crc_dvld_d = 1'b1;
                    cnt_d      = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) state_d = S_WAIT;
                end
            end
            // crc_dvld for the last byte lands here; crc_val settles on exit.
            S_WAIT: state_d = S_CRC_HI;
            S_CRC_HI, S_CRC_LO: begin
                if (!mode_q) begin
                    out_vld  = 1'b1;
                    out_data = (state_q == S_CRC_HI) ? crc_val[15:8] : crc_val[7:0];
                    hs       = out_rdy;
                end else begin
                    in_rdy = 1'b1;
                    hs     = in_vld;
                end
                if (hs) begin
                    if (state_q == S_CRC_HI) begin
                        if (mode_q) rx_crc_d[15:8] = in_data;
                        state_d = S_CRC_LO;
                    end else if (mode_q) begin
                        rx_crc_d[7:0] = in_data;
                        state_d       = S_CHECK;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_CHECK: begin
                crc_err_d = (rx_crc_q != crc_val);
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef MMC_BLK_CRC_TIMEOUT_EN
        idle_d = idle_q;
        to_d   = to_q;
        if (state_q == S_INIT) begin
            idle_d = '0;
            to_d   = 1'b0;
        end else if (state_q == S_DATA || state_q == S_CRC_HI || state_q == S_CRC_LO) begin
            if (hs) begin
                idle_d = '0;
            end else if (idle_q == TO_LAST) begin
                idle_d    = '0;
                to_d      = 1'b1;
                crc_err_d = 1'b1;
                done_d    = 1'b1;
                state_d   = S_IDLE;
            end else begin
                idle_d = idle_q + TO_W'(1);
            end
        end
`endif
    end

    // State and control registers; rst returns everything to idle defaults.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            cnt_q      <= '0;
            rx_crc_q   <= 16'h0000;
            done_q     <= 1'b0;
            crc_err_q  <= 1'b0;
            crc_rst_q  <= 1'b1;
            crc_dvld_q <= 1'b0;
            crc_data_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            rx_crc_q   <= rx_crc_d;
            done_q     <= done_d;
            crc_err_q  <= crc_err_d;
            crc_rst_q  <= crc_rst_d;
            crc_dvld_q <= crc_dvld_d;
            crc_data_q <= crc_data_d;
        end
    end

`ifdef MMC_BLK_CRC_TIMEOUT_EN
    // Idle-cycle counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q <= '0;
            to_q   <= 1'b0;
        end else begin
            idle_q <= idle_d;
            to_q   <= to_d;
        end
    end

    assign timeout = to_q;
`endif

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign crc_err  = crc_err_q;
    assign crc_rst  = crc_rst_q;
    assign crc_dvld = crc_dvld_q;
    assign crc_data = crc_data_q;

endmodule

// File: tb/tb_mmc_blk_crc_seq.sv
// Bench for mmc_blk_crc_seq: random TX/RX blocks against a message-level CRC16
// reference, with a queue scoreboard checked by an independent monitor.
module tb_mmc_blk_crc_seq;

    localparam int BL = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, mode, in_vld, out_rdy;
    logic [7:0]  in_data;
    logic        busy, done, crc_err, in_rdy, out_vld, crc_rst, crc_dvld;
    logic [7:0]  out_data, crc_data;
    logic [15:0] crc_val = 16'h0000;

    // Second instance with a one-byte block.
    logic        start1, in_vld1;
    logic        mode1 = 1'b0;
    logic        out_rdy1 = 1'b1;
    logic [7:0]  in_data1;
    logic        busy1, done1, crc_err1, in_rdy1, out_vld1, crc_rst1, crc_dvld1;
    logic [7:0]  out_data1, crc_data1;
    logic [15:0] crc_val1 = 16'h0000;
`ifdef MMC_BLK_CRC_TIMEOUT_EN
    logic        timeout, timeout1;
`endif

    mmc_blk_crc_seq #(.BLK_LEN(BL)) u_dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy), .done(done),
        .crc_err(crc_err), .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
        .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy), .crc_rst(crc_rst),
        .crc_data(crc_data), .crc_dvld(crc_dvld), .crc_val(crc_val)
`ifdef MMC_BLK_CRC_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    mmc_blk_crc_seq #(.BLK_LEN(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode1), .busy(busy1), .done(done1),
        .crc_err(crc_err1), .in_data(in_data1), .in_vld(in_vld1), .in_rdy(in_rdy1),
        .out_data(out_data1), .out_vld(out_vld1), .out_rdy(out_rdy1), .crc_rst(crc_rst1),
        .crc_data(crc_data1), .crc_dvld(crc_dvld1), .crc_val(crc_val1)
`ifdef MMC_BLK_CRC_TIMEOUT_EN
        , .timeout(timeout1)
`endif
    );

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        failures++;
        $display("FAIL %s: %s", name, what);
    endtask

    // CRC-16/CCITT (poly 0x1021, init 0), bit-serial, MSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = (r << 1) ^ 16'h1021;
            else              r = r << 1;
        end
        return r;
    endfunction

    function automatic logic [15:0] crc16_msg(input logic [7:0] m[$]);
        logic [15:0] r;
        r = 16'h0000;
        foreach (m[i]) r = crc16_byte(r, m[i]);
        return r;
    endfunction

    // Stand-in CRC engines: register updates one cycle after crc_dvld.
    always @(posedge clk) begin
        if (crc_rst)       crc_val <= 16'h0000;
        else if (crc_dvld) crc_val <= crc16_byte(crc_val, crc_data);
        if (crc_rst1)       crc_val1 <= 16'h0000;
        else if (crc_dvld1) crc_val1 <= crc16_byte(crc_val1, crc_data1);
    end

    // Downstream ready: 0 random, 1 always ready, 2 toggling.
    int rdy_mode = 1;
    initial begin
        out_rdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       out_rdy = 1'($urandom_range(0, 1));
                1:       out_rdy = 1'b1;
                default: out_rdy = ~out_rdy;
            endcase
        end
    end

    typedef struct { bit tx; bit err; } res_t;
    logic [7:0] exp_q[$];
    res_t       res_q[$];
    int         done_cnt = 0;

    // Monitor: compares every emitted byte and every done against the queues.
    initial begin
        int cyc, last_hs, dv_cnt;
        bit prev_hold;
        logic [7:0] prev_data;
        res_t r;
        cyc = 0; last_hs = -10; dv_cnt = 0; prev_hold = 0; prev_data = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_hold = 0;
                dv_cnt    = 0;
            end else begin
                if (prev_hold) begin
                    chk("hold_vld", out_vld, 1);
                    chk("hold_data", out_data, prev_data);
                end
                prev_hold = out_vld && !out_rdy;
                prev_data = out_data;
                if (crc_dvld) dv_cnt++;
                if (out_vld && out_rdy) begin
                    if (exp_q.size() == 0) fail_now("out_extra", $sformatf("got byte 0x%0h, required none", out_data));
                    else chk("out_byte", out_data, exp_q.pop_front());
                    last_hs = cyc;
                end
                if (done) begin
                    done_cnt++;
                    if (res_q.size() == 0) begin
                        fail_now("done_extra", "got done=1, required no done");
                    end else begin
                        r = res_q.pop_front();
                        chk("crc_err", crc_err, r.err);
                        chk("dvld_count", dv_cnt, BL);
                        if (r.tx) chk("done_latency", cyc - last_hs, 1);
                    end
                    dv_cnt = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        int n;
        bit got;
        n = 0; got = 0;
        in_data = b;
        in_vld  = 1'b1;
        while (!got && n < 200) begin
            @(negedge clk);
            got = in_rdy;
            tick();
            n++;
        end
        in_vld = 1'b0;
        ok = got;
        if (!got) fail_now("send_byte", "got no in_rdy within 200 cycles, required acceptance");
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic recover();
        exp_q.delete();
        res_q.delete();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic run_block(input bit rx, input bit bad, input bit poke);
        logic [7:0] pl[$];
        logic [15:0] c, x;
        bit ok;
        res_t r;
        int tgt, n;
        for (int i = 0; i < BL; i++) pl.push_back(8'($urandom));
        c = crc16_msg(pl);
        x = bad ? 16'($urandom_range(1, 65535)) : 16'h0000;
        foreach (pl[i]) exp_q.push_back(pl[i]);
        if (!rx) begin
            exp_q.push_back(c[15:8]);
            exp_q.push_back(c[7:0]);
        end
        r.tx = !rx;
        r.err = rx && bad;
        res_q.push_back(r);
        tgt = done_cnt + 1;
        mode = rx; start = 1'b1;
        tick();
        start = 1'b0; mode = 1'($urandom);
        @(negedge clk);
        chk("init_busy", busy, 1);
        chk("init_crc_rst", crc_rst, 1);
        chk("init_in_rdy", in_rdy, 0);
        tick();
        @(negedge clk);
        chk("data_in_rdy", in_rdy, out_rdy);
        chk("data_crc_rst", crc_rst, 0);
        tick();
        for (int i = 0; i < BL; i++) begin
            send_byte(pl[i], ok);
            if (!ok) begin recover(); return; end
            if (poke && i == 0) begin
                start = 1'b1; mode = !rx;
                tick();
                start = 1'b0;
            end
        end
        if (rx) begin
            send_byte(c[15:8] ^ x[15:8], ok);
            if (ok) send_byte(c[7:0] ^ x[7:0], ok);
            if (!ok) begin recover(); return; end
        end
        n = 0;
        while (done_cnt < tgt && n < 100) begin tick(); n++; end
        if (done_cnt < tgt) begin
            fail_now("block_done", "got no done within 100 cycles, required done pulse");
            recover();
            return;
        end
        chk("exp_drained", exp_q.size(), 0);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500us, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q1[$];
        logic [7:0] m1[$];
        logic [15:0] c1;
        bit ok, seen;
        int n, dv1, d0;
        rst = 1'b1; start = 1'b0; mode = 1'b0; in_vld = 1'b0; in_data = 8'h00;
        start1 = 1'b0; in_vld1 = 1'b0; in_data1 = 8'h00;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_crc_err", crc_err, 0);
        chk("rst_in_rdy", in_rdy, 0);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_crc_dvld", crc_dvld, 0);
        chk("rst_crc_rst", crc_rst, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_crc_data", crc_data, 0);
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("idle_crc_rst", crc_rst, 0);
        tick();

        // Directed: always-ready TX, RX good, RX bad with held error.
        rdy_mode = 1;
        run_block(0, 0, 0);
        run_block(1, 0, 0);
        run_block(1, 1, 0);
        repeat (3) tick();
        chk("err_held", crc_err, 1);
        run_block(0, 0, 0);
        chk("err_cleared", crc_err, 0);

        // Toggling backpressure.
        rdy_mode = 2;
        run_block(0, 0, 0);
        run_block(1, 1, 1);

        // Random traffic.
        rdy_mode = 0;
        for (int k = 0; k < 20; k++)
            run_block(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));

        // Reset in the middle of a TX block.
        rdy_mode = 1;
        d0 = done_cnt;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        send_byte(8'h11, ok);
        send_byte(8'h22, ok);
        start = 1'b1; mode = 1'b1;
        tick();
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_crc_rst", crc_rst, 1);
        chk("midrst_done", done, 0);
        chk("midrst_out_vld", out_vld, 0);
        chk("midrst_in_rdy", in_rdy, 0);
        tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("midrst_no_done", done_cnt, d0);
        chk("midrst_drained", exp_q.size(), 0);
        exp_q.delete();
        run_block(0, 0, 0);
        run_block(1, 0, 0);

        // One-byte block on the second instance.
        m1.push_back(8'h7E);
        c1 = crc16_msg(m1);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        in_data1 = 8'h7E; in_vld1 = 1'b1;
        n = 0; dv1 = 0; seen = 0;
        while (!seen && n < 30) begin
            @(negedge clk);
            ok = in_vld1 && in_rdy1;
            if (out_vld1 && out_rdy1) q1.push_back(out_data1);
            if (crc_dvld1) dv1++;
            if (done1) seen = 1;
            tick();
            if (ok) in_vld1 = 1'b0;
            n++;
        end
        chk("b1_done", seen, 1);
        chk("b1_nbytes", q1.size(), 3);
        if (q1.size() == 3) begin
            chk("b1_byte0", q1[0], 8'h7E);
            chk("b1_crc_hi", q1[1], c1[15:8]);
            chk("b1_crc_lo", q1[2], c1[7:0]);
        end
        chk("b1_dvld", dv1, 1);
        chk("b1_crc_err", crc_err1, 0);
        chk("b1_busy", busy1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmc_blk_crc_seq.md
Name: mmc_blk_crc_seq

Overview:
- Sequences one MMC data block through the shared byte-wide CRC16 engine (crc16_d8), in transmit or receive mode.
- TX: passes BLK_LEN payload bytes through, then appends the 2-byte CRC, MSB first.
- RX: passes BLK_LEN payload bytes through, consumes the 2 trailing CRC bytes and flags a mismatch.
- Sits between the MMC byte shifter and the block buffer in mmc_controller; owns reset and data-valid control of the CRC engine.

Parameters:
- BLK_LEN, 512, payload bytes per block; minimum 1.
- TO_CYCLES, 65535, idle cycles before abort; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  begin a block; sampled in IDLE only.
- mode  in  1  0 = TX, 1 = RX; latched at start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at end of block.
- crc_err  out  1  RX result; valid with done, held until next start.
- in_data  in  8  byte stream in.
- in_vld  in  1  in_data valid.
- in_rdy  out  1  byte accepted when in_vld & in_rdy.
- out_data  out  8  byte stream out.
- out_vld  out  1  out_data valid.
- out_rdy  in  1  downstream ready.
- crc_rst  out  1  CRC engine reset.
- crc_data  out  8  CRC engine data.
- crc_dvld  out  1  CRC engine data valid.
- crc_val  in  16  CRC engine register; updates 1 cycle after crc_dvld.
- timeout  out  1  abort flag; present only with the optional feature.

Behaviour:
- Reset values: busy, done, crc_err, in_rdy, out_vld, crc_dvld, timeout = 0; crc_rst = 1; out_data, crc_data = 0; FSM = IDLE; byte counter = 0.
- States: IDLE, INIT, DATA, WAIT, CRC_HI, CRC_LO, CHECK.
- IDLE:
  - crc_rst = 0.
  - start = 1 -> latch mode, go to INIT.
- INIT:
  - crc_rst = 1 for exactly 1 cycle.
  - Clear counter and crc_err.
  - Go to DATA.
- DATA (both modes):
  - Combinational pass-through: out_data = in_data, out_vld = in_vld, in_rdy = out_rdy.
  - On each handshake (in_vld & out_rdy): crc_data = in_data, crc_dvld = 1, counter increments.
  - The handshake that makes counter reach BLK_LEN goes to WAIT.
  - Counter width: clog2(BLK_LEN+1).
- WAIT:
  - 1 cycle; in_rdy = 0, out_vld = 0; lets crc_val absorb the last byte.
  - TX -> CRC_HI. RX -> CRC_HI.
- CRC_HI / CRC_LO, TX mode:
  - out_vld = 1; out_data = crc_val[15:8], then crc_val[7:0].
  - Advance on out_rdy; in_rdy = 0; crc_dvld = 0.
  - After CRC_LO handshake: done pulse, go to IDLE.
- CRC_HI / CRC_LO, RX mode:
  - in_rdy = 1; out_vld = 0.
  - Capture the received CRC high byte, then the low byte, on in_vld.
  - After CRC_LO -> CHECK.
- CHECK (RX only):
  - crc_err = (captured != crc_val).
  - done pulse, go to IDLE.
- crc_val is not updated during CRC byte transfer, because crc_dvld = 0 outside DATA.
- start while busy: ignored.
- in_vld outside DATA/RX-CRC states: ignored; not accepted.
- TX backpressure: out_rdy low holds CRC_HI/CRC_LO indefinitely; out_data must stay stable.
- BLK_LEN = 1: DATA lasts exactly one handshake.
- rst mid-block: immediate return to reset values; no done pulse.
- Latency, start to first possible data handshake: 2 cycles (start edge -> INIT -> DATA).

Optional Feature:
- Macro: MMC_BLK_CRC_TIMEOUT_EN.
- Defined:
  - An idle counter clears on every handshake and on entry to DATA.
  - It increments each cycle in DATA/CRC_HI/CRC_LO without a handshake.
  - Reaching TO_CYCLES -> timeout = 1 and crc_err = 1 together with a done pulse, then IDLE.
  - timeout is held until the next start.
- Undefined: no counter, no timeout port; the block waits forever.

Test Plan:
- TX, BLK_LEN=4, bytes 01 02 03 04, out_rdy=1, bench crc_val held 0xA55A -> out stream 01 02 03 04 A5 5A; crc_dvld exactly 4 cycles; done 1 cycle after 5A; crc_err = 0.
- RX, BLK_LEN=4, crc_val = 0x1234, input 01 02 03 04 12 34 -> crc_err = 0 with done; input ending 12 35 -> crc_err = 1.
- TX with out_rdy toggling 1,0,1,0 -> each byte emitted once; crc_dvld count = 4; A5 held stable while out_rdy = 0.
- start pulsed during DATA; rst asserted after byte 2 -> start ignored; on rst busy = 0, crc_rst = 1, no done; next start runs a clean block.
- BLK_LEN=1, TX byte 0x7E -> INIT, one DATA handshake, WAIT, 2 CRC bytes, done.
- MMC_BLK_CRC_TIMEOUT_EN with TO_CYCLES=8, in_vld stuck low in DATA -> timeout = 1, crc_err = 1, done on the 8th idle cycle.
